// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays a requested amount greedily as timed eject pulses on
// three denomination hoppers, skipping empty ones, then pulses done (with err).
module vend_change_dispenser #(
  parameter int AMT_W     = 8,
  parameter int D_HI      = 10,
  parameter int D_MID     = 5,
  parameter int D_LO      = 1,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             empty_hi,
  input  logic             empty_mid,
  input  logic             empty_lo,
  output logic             busy,
  output logic             eject_hi,
  output logic             eject_mid,
  output logic             eject_lo,
  output logic [AMT_W-1:0] remain,
  output logic             done,
  output logic             err
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [AMT_W-1:0] V_HI       = AMT_W'(D_HI);
  localparam logic [AMT_W-1:0] V_MID      = AMT_W'(D_MID);
  localparam logic [AMT_W-1:0] V_LO       = AMT_W'(D_LO);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    FINISH
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [AMT_W-1:0] remain_n;
  logic [2:0]       eject, eject_n;
  logic             err_n;

  // Eject vector bit order is {hi, mid, lo}; only one bit is ever set.
  assign eject_hi  = eject[2];
  assign eject_mid = eject[1];
  assign eject_lo  = eject[0];

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    remain_n = remain;
    eject_n  = eject;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          remain_n = amount;
          state_n  = SELECT;
        end
      end
      SELECT: begin
        if (remain == '0) begin
          state_n = FINISH;
        end else if (!empty_hi && remain >= V_HI) begin
          remain_n = remain - V_HI;
          eject_n  = 3'b100;
          cnt_n    = PULSE_LAST;
          state_n  = PULSE;
        end else if (!empty_mid && remain >= V_MID) begin
          remain_n = remain - V_MID;
          eject_n  = 3'b010;
          cnt_n    = PULSE_LAST;
          state_n  = PULSE;
        end else if (!empty_lo && remain >= V_LO) begin
          remain_n = remain - V_LO;
          eject_n  = 3'b001;
          cnt_n    = PULSE_LAST;
          state_n  = PULSE;
        end else begin
          err_n   = 1'b1;
          state_n = FINISH;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          eject_n = 3'b000;
          cnt_n   = GAP_LAST;
          state_n = GAP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = SELECT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        eject_n = 3'b000;
      end
    endcase
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      remain <= '0;
      eject  <= 3'b000;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      remain <= remain_n;
      eject  <= eject_n;
      busy   <= (state_n != IDLE);
      done   <= (state_n == FINISH);
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: directed and random payouts checked cycle by
// cycle against a timeline built from a greedy coin-list model.
module tb_vend_change_dispenser;

  localparam int AMT_W = 8;
  localparam int P     = 4;
  localparam int G     = 4;
  localparam int COIN  = 1 + P + G;

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             empty_hi, empty_mid, empty_lo;
  logic             busy, eject_hi, eject_mid, eject_lo, done, err;
  logic [AMT_W-1:0] remain;

  int total = 0;
  int bad   = 0;

  vend_change_dispenser #(
    .AMT_W(AMT_W), .D_HI(10), .D_MID(5), .D_LO(1), .PULSE_CYC(P), .GAP_CYC(G)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount),
    .empty_hi(empty_hi), .empty_mid(empty_mid), .empty_lo(empty_lo),
    .busy(busy), .eject_hi(eject_hi), .eject_mid(eject_mid), .eject_lo(eject_lo),
    .remain(remain), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Greedy payout computed from the coin values; 0=hi(10), 1=mid(5), 2=lo(1).
  task automatic modelPayout(input int amt, input bit ehi, input bit emid, input bit elo,
                             output int coins[$], output int final_rem, output bit merr);
    int rem = amt;
    coins = {};
    merr  = 1'b0;
    while (rem > 0) begin
      if (!ehi && rem >= 10) begin coins.push_back(0); rem -= 10; end
      else if (!emid && rem >= 5) begin coins.push_back(1); rem -= 5; end
      else if (!elo && rem >= 1) begin coins.push_back(2); rem -= 1; end
      else begin merr = 1'b1; break; end
    end
    final_rem = rem;
  endtask

  function automatic int coinValue(input int d);
    return (d == 0) ? 10 : (d == 1) ? 5 : 1;
  endfunction

  // One transaction; busy_req_cycle > 0 injects a stray req during that cycle.
  task automatic applyStimulus(input int amt, input bit ehi, input bit emid, input bit elo,
                               input int busy_req_cycle);
    int coins[$];
    int final_rem, fin, exp_rem;
    int exp_ej[3];
    bit merr;
    modelPayout(amt, ehi, emid, elo, coins, final_rem, merr);
    fin = 2 + coins.size() * COIN;
    @(negedge clk);
    req = 1'b1; amount = AMT_W'(amt);
    empty_hi = ehi; empty_mid = emid; empty_lo = elo;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= fin + 1; c++) begin
      @(negedge clk);
      exp_rem = amt;
      exp_ej  = '{0, 0, 0};
      for (int i = 0; i < coins.size(); i++) begin
        if (1 + i * COIN < c) exp_rem -= coinValue(coins[i]);
        if (c >= 2 + i * COIN && c <= 1 + P + i * COIN) exp_ej[coins[i]] = 1;
      end
      checkOutput($sformatf("busy amt=%0d c=%0d", amt, c), int'(busy), int'(c <= fin));
      checkOutput($sformatf("done amt=%0d c=%0d", amt, c), int'(done), int'(c == fin));
      checkOutput($sformatf("remain amt=%0d c=%0d", amt, c), int'(remain), exp_rem);
      checkOutput($sformatf("ej_hi amt=%0d c=%0d", amt, c), int'(eject_hi), exp_ej[0]);
      checkOutput($sformatf("ej_mid amt=%0d c=%0d", amt, c), int'(eject_mid), exp_ej[1]);
      checkOutput($sformatf("ej_lo amt=%0d c=%0d", amt, c), int'(eject_lo), exp_ej[2]);
      if (c == fin) begin
        checkOutput($sformatf("err amt=%0d", amt), int'(err), int'(merr));
        checkOutput($sformatf("final_rem amt=%0d", amt), int'(remain), final_rem);
      end
      if (c == busy_req_cycle) begin
        req = 1'b1; amount = 8'd7;
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    bit e0, e1, e2;
    int a;
    bit saw_done;
    rst = 1'b1; req = 1'b0; amount = '0;
    empty_hi = 1'b0; empty_mid = 1'b0; empty_lo = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst done", int'(done), 0);
    checkOutput("rst err", int'(err), 0);
    checkOutput("rst remain", int'(remain), 0);
    checkOutput("rst ejects", int'({eject_hi, eject_mid, eject_lo}), 0);
    rst = 1'b0;

    applyStimulus(16, 0, 0, 0, 0);
    applyStimulus(10, 1, 0, 0, 0);
    applyStimulus(3, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(16, 0, 0, 0, 5);
    applyStimulus(16, 0, 0, 0, 29);
    applyStimulus(255, 0, 0, 0, 0);
    applyStimulus(23, 0, 1, 0, 0);
    applyStimulus(9, 0, 1, 1, 0);

    // Reset during the first eject_hi pulse truncates it and suppresses done.
    @(negedge clk);
    req = 1'b1; amount = 8'd16;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre-rst ej_hi", int'(eject_hi), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst ej_hi", int'(eject_hi), 0);
    checkOutput("midrst remain", int'(remain), 0);
    checkOutput("midrst busy", int'(busy), 0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checkOutput("midrst no done", int'(saw_done), 0);

    // rst and req on the same edge: the request is dropped.
    @(negedge clk);
    rst = 1'b1; req = 1'b1; amount = 8'd16;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    checkOutput("rst+req busy", int'(busy), 0);
    checkOutput("rst+req remain", int'(remain), 0);

    for (int t = 0; t < 25; t++) begin
      a  = $urandom_range(0, 80);
      e0 = ($urandom_range(0, 3) == 0);
      e1 = ($urandom_range(0, 3) == 0);
      e2 = ($urandom_range(0, 3) == 0);
      applyStimulus(a, e0, e1, e2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
